// File: rtl/reg_file_mp.sv
// Dual-write register file with reservation bits and a sequential clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_mp #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                SP_ADDR = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_a,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(SP_ADDR);
  localparam logic [ADDR_W-1:0] LAST   = '1;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [NREG-1:0]     r_pend;
  logic [NREG-1:0]     w_pend_nxt;
  logic                w_wea;
  logic                w_web;
  logic                w_idle;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wea    = w_idle && we_a && (wa_a != '0);
  assign w_web    = w_idle && we_b && (wa_b != '0);
  assign clr_busy = (r_state == S_CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = ADDR_W'(1);
        end
      end
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Port B is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == SP_ADDR) ? SP_INIT : '0;
      end
    end else if (r_state == S_CLEAR) begin
      r_regs[r_cnt] <= (r_cnt == SP_IDX) ? SP_INIT : '0;
    end else begin
      if (w_wea) r_regs[wa_a] <= wd_a;
      if (w_web) r_regs[wa_b] <= wd_b;
    end
  end

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wea) w_pend_nxt[wa_a] = 1'b0;
    if (w_web) w_pend_nxt[wa_b] = 1'b0;
    if (rsv_en && (rsv_addr != '0)) w_pend_nxt[rsv_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else if (w_idle) begin
      r_pend <= clr_req ? '0 : w_pend_nxt;
    end
  end

  always_comb begin
    rd1   = (ra1 == '0) ? '0 : r_regs[ra1];
    rd2   = (ra2 == '0) ? '0 : r_regs[ra2];
    busy1 = r_pend[ra1];
    busy2 = r_pend[ra2];
`ifdef REGFILE_BYPASS_EN
    if (ra1 != '0) begin
      if (w_wea && (wa_a == ra1)) begin
        rd1   = wd_a;
        busy1 = 1'b0;
      end
      if (w_web && (wa_b == ra1)) begin
        rd1   = wd_b;
        busy1 = 1'b0;
      end
    end
    if (ra2 != '0) begin
      if (w_wea && (wa_a == ra2)) begin
        rd2   = wd_a;
        busy2 = 1'b0;
      end
      if (w_web && (wa_b == ra2)) begin
        rd2   = wd_b;
        busy2 = 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized bench for reg_file_mp against an array-based reference model.
// Directed scenarios cover collisions, reservations, clear and reset abort.
module tb_reg_file_mp;

  localparam int          NR  = 32;
  localparam int          SPA = 29;
  localparam logic [31:0] SPI = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa_a, wa_b, rsv_addr;
  logic [31:0] rd1, rd2, wd_a, wd_b;
  logic        we_a, we_b, rsv_en, clr_req;
  logic        busy1, busy2, clr_busy;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we_a(we_a), .we_b(we_b), .wa_a(wa_a), .wa_b(wa_b),
    .wd_a(wd_a), .wd_b(wd_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1), .busy2(busy2),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_regs [NR];
  bit          m_pend [NR];
  int          m_idx;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = (i == SPA) ? SPI : 32'h0;
      m_pend[i] = 1'b0;
    end
    m_idx = 0;
  endtask

  function automatic bit hit_a(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
    return m_idx == 0 && ra != 0 && we_a && wa_a == ra;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit hit_b(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
    return m_idx == 0 && ra != 0 && we_b && wa_b == ra;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] ra);
    if (ra == 0) return 32'h0;
    if (hit_b(ra)) return wd_b;
    if (hit_a(ra)) return wd_a;
    return m_regs[ra];
  endfunction

  function automatic logic m_busy(input logic [4:0] ra);
    if (ra == 0 || hit_a(ra) || hit_b(ra)) return 1'b0;
    return m_pend[ra];
  endfunction

  task automatic m_edge();
    if (m_idx != 0) begin
      m_regs[m_idx] = (m_idx == SPA) ? SPI : 32'h0;
      m_idx = (m_idx == NR - 1) ? 0 : m_idx + 1;
    end else begin
      if (we_a && wa_a != 0) m_regs[wa_a] = wd_a;
      if (we_b && wa_b != 0) m_regs[wa_b] = wd_b;
      if (clr_req) begin
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        m_idx = 1;
      end else begin
        if (we_a) m_pend[wa_a] = 1'b0;
        if (we_b) m_pend[wa_b] = 1'b0;
        if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".rd1"}, rd1, m_rd(ra1));
    check({tag, ".rd2"}, rd2, m_rd(ra2));
    check({tag, ".busy1"}, 32'(busy1), 32'(m_busy(ra1)));
    check({tag, ".busy2"}, 32'(busy2), 32'(m_busy(ra2)));
    check({tag, ".clr_busy"}, 32'(clr_busy), 32'(m_idx != 0));
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0;
    rsv_en = 0; rsv_addr = 0; clr_req = 0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick(input string tag);
    #1;
    check_outs(tag);
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    int busy_n;
    idle();
    ra1 = 5'd29; ra2 = 5'd3;
    reset = 1'b0;
    m_reset();
    #12;
    check_outs("in_reset");
    @(negedge clk);
    reset = 1'b1;
    ra1 = 5'd29; ra2 = 5'd0;
    #1;
    check("sp_init", rd1, SPI);
    check("r0_zero", rd2, 32'h0);
    tick("post_reset");

    we_a = 1; wa_a = 5; wd_a = 32'hA5A5_0001;
    we_b = 1; wa_b = 5; wd_b = 32'h0000_BEEF;
    ra1 = 5;
`ifdef REGFILE_BYPASS_EN
    #1;
    check("bypass_b_wins", rd1, 32'h0000_BEEF);
`endif
    tick("dual_write");
    idle();
    #1;
    check("port_b_wins", rd1, 32'h0000_BEEF);
    tick("after_dual");

    rsv_en = 1; rsv_addr = 7; ra1 = 7;
    tick("rsv7");
    idle();
    #1;
    check("rsv7_busy", 32'(busy1), 32'd1);
    we_a = 1; wa_a = 7; wd_a = 32'h77; rsv_en = 1; rsv_addr = 7;
    tick("rsv_and_wr7");
    idle();
    #1;
    check("set_wins", 32'(busy1), 32'd1);
    we_b = 1; wa_b = 7; wd_b = 32'h78;
    tick("wr7");
    idle();
    #1;
    check("wr_clears", 32'(busy1), 32'd0);

    we_a = 1; wa_a = 3; wd_a = 32'd1234;
    we_b = 1; wa_b = 29; wd_b = 32'd99;
    rsv_en = 1; rsv_addr = 9;
    tick("load");
    idle();
    clr_req = 1;
    tick("clr_req");
    idle();
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!clr_busy) break;
      busy_n++;
      we_a = 1; wa_a = 3; wd_a = $urandom;
      rsv_en = 1; rsv_addr = 5'd11;
      ra1 = 3; ra2 = 29;
      tick("clearing");
    end
    idle();
    check("clr_len", busy_n, 32'd31);
    ra1 = 3; ra2 = 29;
    #1;
    check("clr_r3", rd1, 32'h0);
    check("clr_sp", rd2, SPI);
    for (int a = 0; a < NR; a++) begin
      ra1 = 5'(a);
      #1;
      check("clr_busy_all", 32'(busy1), 32'd0);
    end
    tick("clr_done");

    we_a = 1; wa_a = 4; wd_a = 32'h44;
    tick("pre_abort");
    idle();
    clr_req = 1;
    tick("clr2");
    idle();
    for (int k = 0; k < 9; k++) tick("clr2_run");
    #2;
    reset = 1'b0;
    m_reset();
    ra1 = 4; ra2 = 29;
    #1;
    check("abort_busy", 32'(clr_busy), 32'd0);
    check("abort_r4", rd1, 32'h0);
    check("abort_sp", rd2, SPI);
    @(negedge clk);
    reset = 1'b1;
    we_a = 1; wa_a = 4; wd_a = 32'h4444_0004;
    tick("post_abort_wr");
    idle();
    #1;
    check("r4_after_abort", rd1, 32'h4444_0004);
    tick("post_abort");

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        m_reset();
        #1;
        check_outs("rnd_reset");
        @(negedge clk);
        reset = 1'b1;
      end
      ra1 = raddr(); ra2 = raddr();
      we_a = 1'($urandom); wa_a = raddr(); wd_a = $urandom;
      we_b = 1'($urandom); wa_b = raddr(); wd_b = $urandom;
      rsv_en = 1'($urandom); rsv_addr = raddr();
      clr_req = ($urandom_range(0, 299) == 0);
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
